// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the
// byte-wide instruction fetch controller.
package fetch_pkg;

  localparam int          MEM_DEPTH_DEF = 1024;
  localparam logic [31:0] NOP           = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    COLLECT,
    DONE,
    WRITE
  } fetch_state_e;

endpackage

// File: rtl/word_assembler.sv
// Shifts memory bytes into a 32-bit word, first byte
// landing in the most significant position.
module word_assembler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_clear,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic [2:0]  o_count
);

  logic [31:0] r_word;
  logic [2:0]  r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_word  <= '0;
      r_count <= '0;
    end else if (i_shift) begin
      r_word  <= {r_word[23:0], i_byte};
      r_count <= r_count + 3'd1;
    end
  end

  assign o_word  = r_word;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_controller.sv
// Serialises 32-bit instruction fetches over a byte
// memory and arbitrates a program loader port.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       instruction,
  output logic              fetch_err,
  input  logic              load_valid,
  input  logic [31:0]       load_addr,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  output logic              load_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  fetch_state_e r_state;
  fetch_state_e w_next;

  logic [ADDR_W-1:0] r_faddr;
  logic [ADDR_W-1:0] r_laddr;
  logic [7:0]        r_ldata;
  logic [1:0]        r_idx;
  logic              r_err;
  logic              r_lerr;
  logic [31:0]       r_instr;

  logic        w_idle;
  logic        w_load_go;
  logic        w_fetch_go;
  logic        w_fetch_ok;
  logic        w_load_ok;
  logic        w_shift;
  logic [31:0] w_word;
  logic [2:0]  w_cnt;
  logic [31:0] w_instr;

  assign w_idle     = (r_state == IDLE);
  assign w_load_go  = w_idle && load_valid;
  assign w_fetch_go = w_idle && fetch_req
                   && !load_valid;
  // 32-bit compare so addresses near 2^32 never wrap in.
  assign w_fetch_ok = (fetch_addr[1:0] == 2'b00)
                   && (fetch_addr <= 32'(MEM_DEPTH - 4));
  assign w_load_ok  = (load_addr < 32'(MEM_DEPTH));
  assign w_shift    = (r_state == READ)
                   || (r_state == COLLECT);

  assign fetch_ready = w_idle && !load_valid;
  assign load_ready  = w_idle;
  assign instruction = w_instr;

  word_assembler u_asm (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_fetch_go),
    .i_shift (w_shift),
    .i_byte  (mem_rdata),
    .o_word  (w_word),
    .o_count (w_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_load_go)
          w_next = WRITE;
        else if (w_fetch_go)
          w_next = w_fetch_ok ? READ : DONE;
      end
      READ:    if (r_idx == 2'd3) w_next = COLLECT;
      COLLECT: if (w_cnt == 3'd3) w_next = DONE;
      DONE:    w_next = IDLE;
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    fetch_valid = 1'b0;
    fetch_err   = 1'b0;
    load_err    = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    w_instr     = r_instr;
    unique case (r_state)
      // Byte 0 address goes out in the accept cycle.
      IDLE: begin
        if (w_fetch_go && w_fetch_ok)
          mem_addr = fetch_addr[ADDR_W-1:0];
      end
      READ: mem_addr = r_faddr + ADDR_W'(r_idx);
      COLLECT: ;
      DONE: begin
        fetch_valid = 1'b1;
        fetch_err   = r_err;
        w_instr     = r_err ? NOP : w_word;
      end
      WRITE: begin
        mem_addr  = r_laddr;
        mem_wdata = r_ldata;
        mem_we    = !r_lerr;
        load_err  = r_lerr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_faddr <= '0;
      r_laddr <= '0;
      r_ldata <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_lerr  <= 1'b0;
      r_instr <= '0;
    end else begin
      if (w_fetch_go) begin
        r_faddr <= fetch_addr[ADDR_W-1:0];
        r_err   <= !w_fetch_ok;
        r_idx   <= 2'd1;
      end else if (r_state == READ) begin
        r_idx <= r_idx + 2'd1;
      end
      if (w_load_go) begin
        r_laddr <= load_addr[ADDR_W-1:0];
        r_ldata <= load_byte;
        r_lerr  <= !w_load_ok;
      end
      if (r_state == DONE)
        r_instr <= w_instr;
    end
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, meaning byte capacity of the instruction memory.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning the memory byte-address width, clog2(MEM_DEPTH).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port fetch_req  input  1  core requests one instruction.
REQ-006 SHALL have port fetch_addr  input  32  byte address of the requested instruction.
REQ-007 SHALL have port fetch_ready  output  1  controller can accept a fetch this cycle.
REQ-008 SHALL have port fetch_valid  output  1  one-cycle pulse: instruction/fetch_err are valid.
REQ-009 SHALL have port instruction  output  32  assembled instruction word.
REQ-010 SHALL have port fetch_err  output  1  misaligned or out-of-range fetch, qualified by fetch_valid.
REQ-011 SHALL have port load_valid  input  1  program loader offers one byte.
REQ-012 SHALL have port load_addr  input  32  loader byte address.
REQ-013 SHALL have port load_byte  input  8  loader data.
REQ-014 SHALL have port load_ready  output  1  controller accepts the loader byte this cycle.
REQ-015 SHALL have port load_err  output  1  one-cycle pulse: accepted load byte was out of range and dropped.
REQ-016 SHALL have port mem_addr  output  ADDR_W  byte address to memory.
REQ-017 SHALL have port mem_we  output  1  byte write strobe.
REQ-018 SHALL have port mem_wdata  output  8  byte write data.
REQ-019 SHALL have port mem_rdata  input  8  read byte, valid one cycle after mem_addr (synchronous read).

Function
REQ-020 SHALL implement states IDLE, READ, COLLECT, DONE, WRITE.
REQ-021 Handshakes SHALL complete on valid&&ready at a rising edge; fetch_ready and load_ready SHALL be high only in IDLE.
REQ-022 If fetch_req and load_valid are both high in IDLE, load SHALL win; fetch_ready SHALL be low that cycle.
REQ-023 An in-flight fetch SHALL never be preempted; load waits for return to IDLE.
REQ-024 Accepted fetch at edge T with fetch_addr[1:0]==0 and fetch_addr<=MEM_DEPTH-4: READ drives mem_addr=addr+0..+3 in cycles T..T+3.
REQ-025 COLLECT SHALL capture mem_rdata in cycles T+1..T+4, big-endian: byte addr+0 -> instruction[31:24], addr+3 -> [7:0].
REQ-026 DONE SHALL assert fetch_valid=1, fetch_err=0 in cycle T+5 (5-cycle latency), then return to IDLE.
REQ-027 Misaligned or out-of-range fetch: no memory read; DONE next cycle with fetch_valid=1, fetch_err=1, instruction=32'h00000013.
REQ-028 instruction SHALL hold its value until the next fetch_valid.
REQ-029 Accepted load at edge T: WRITE in cycle T+1 with mem_we=1, mem_addr=load_addr[ADDR_W-1:0], mem_wdata=load_byte; IDLE at T+2.
REQ-030 load_addr>=MEM_DEPTH: mem_we SHALL stay 0 and load_err SHALL pulse in cycle T+1.
REQ-031 mem_we SHALL be 0 outside WRITE; address arithmetic SHALL be 32-bit before range check (no wrap past 32'hFFFFFFFF accepted).

Reset
REQ-032 reset_n low SHALL immediately force IDLE, fetch_valid=0, fetch_err=0, load_err=0, mem_we=0, mem_addr=0, mem_wdata=0, instruction=0.
REQ-033 Reset mid-fetch or mid-write SHALL discard the partial word/write; no fetch_valid after release.
REQ-034 fetch_ready and load_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-035 State encoding, NOP constant 32'h00000013 and MEM_DEPTH default SHALL live in shared package fetch_pkg.
REQ-036 The byte-to-word assembler SHALL be sub-module word_assembler (shift-in, 4-byte count).

Verification
REQ-037 Load bytes 00,02,04,93 to 0..3, fetch 0 -> fetch_valid at T+5, instruction=32'h00020493, fetch_err=0.
REQ-038 fetch_addr=2 -> fetch_valid at T+1, fetch_err=1, instruction=32'h00000013, no mem_addr activity.
REQ-039 fetch_req and load_valid simultaneous in IDLE -> load accepted, fetch accepted two cycles later.
REQ-040 load_valid asserted during fetch -> load_ready=0 until fetch_valid done; byte written after.
REQ-041 load_addr=1024 -> load_err pulse, mem_we=0; fetch_addr=1021 -> fetch_err=1.
REQ-042 reset_n low at T+2 of a fetch -> outputs at reset values, no fetch_valid, ready=1 after release.
